// File: rtl/dsp_preadder_dreg_pkg.sv
// Shared constants for the DSP slice pre-adder stage.
package dsp_preadder_dreg_pkg;

  localparam int unsigned AD_WIDTH     = 25;
  localparam int unsigned D_WIDTH      = 25;
  localparam int unsigned A_WIDTH      = 30;
  localparam int unsigned INMODE_WIDTH = 5;

  // INMODE bit positions
  localparam int unsigned INMODE_ASEL  = 0;
  localparam int unsigned INMODE_AZERO = 1;
  localparam int unsigned INMODE_DEN   = 2;
  localparam int unsigned INMODE_SUB   = 3;
  localparam int unsigned INMODE_BSEL  = 4;

  localparam string USE_DPORT_TRUE  = "TRUE";
  localparam string USE_DPORT_FALSE = "FALSE";

endpackage

// File: rtl/dsp_optreg.sv
// Optional pipeline register: enable, async active-low clear, or pure wire when Stages == 0.
module dsp_optreg #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Stages == 0) begin : g_bypass
    // No storage: clock, clear and enable have no effect on the path.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, en_i};
    assign q_o = d_i;
  end else begin : g_reg
    logic [Width-1:0] val_d, val_q;

    // Load when enabled, otherwise hold.
    always_comb begin
      val_d = val_q;
      if (en_i) val_d = d_i;
    end

    // State register; clear wins over enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) val_q <= '0;
      else         val_q <= val_d;
    end

    assign q_o = val_q;
  end

endmodule

// File: rtl/dsp_preadder_dreg.sv
// Pre-adder stage: optional D/INMODE input registers, 25-bit add/sub, optional AD register.
module dsp_preadder_dreg
  import dsp_preadder_dreg_pkg::*;
#(
  parameter int unsigned DREG      = 1,
  parameter int unsigned ADREG     = 1,
  parameter int unsigned INMODEREG = 1,
  parameter string       USE_DPORT = "TRUE"
) (
  input  logic                    clk,
  input  logic                    RST_n,
  input  logic                    CED,
  input  logic                    CEAD,
  input  logic                    CEINMODE,
  input  logic [INMODE_WIDTH-1:0] INMODE,
  input  logic [D_WIDTH-1:0]      D,
  input  logic [A_WIDTH-1:0]      AMULT,
  output logic                    INMODE_A,
  output logic                    INMODE_B,
  output logic [AD_WIDTH-1:0]     AD
);

  localparam bit UseD = (USE_DPORT == USE_DPORT_TRUE);

  logic [INMODE_WIDTH-1:0] inmode_r;
  logic [D_WIDTH-1:0]      d_r;
  logic [AD_WIDTH-1:0]     a_term, d_term, ad_pre;

  dsp_optreg #(
    .Width  (INMODE_WIDTH),
    .Stages (INMODEREG)
  ) u_inmode_reg (
    .clk_i  (clk),
    .rst_ni (RST_n),
    .en_i   (CEINMODE),
    .d_i    (INMODE),
    .q_o    (inmode_r)
  );

  dsp_optreg #(
    .Width  (D_WIDTH),
    .Stages (DREG)
  ) u_d_reg (
    .clk_i  (clk),
    .rst_ni (RST_n),
    .en_i   (CED),
    .d_i    (D),
    .q_o    (d_r)
  );

  // Pre-adder; all arithmetic wraps modulo 2^25.
  always_comb begin
    a_term = inmode_r[INMODE_AZERO] ? '0 : AMULT[AD_WIDTH-1:0];
    d_term = (UseD && inmode_r[INMODE_DEN]) ? d_r : '0;
    ad_pre = d_term + a_term;
    if (UseD && inmode_r[INMODE_SUB]) ad_pre = d_term - a_term;
  end

  dsp_optreg #(
    .Width  (AD_WIDTH),
    .Stages (ADREG)
  ) u_ad_reg (
    .clk_i  (clk),
    .rst_ni (RST_n),
    .en_i   (CEAD),
    .d_i    (ad_pre),
    .q_o    (AD)
  );

  assign INMODE_A = inmode_r[INMODE_ASEL];
  assign INMODE_B = inmode_r[INMODE_BSEL];

  // Upper AMULT bits belong to the multiplier-side A path, not the pre-adder.
  logic unused_bits;
  assign unused_bits = ^{AMULT[A_WIDTH-1:AD_WIDTH]};

endmodule

// File: tb/tb_dsp_preadder_dreg.sv
module tb_dsp_preadder_dreg;

  logic        clk = 1'b0;
  logic        RST_n;
  logic        CED, CEAD, CEINMODE;
  logic [4:0]  INMODE;
  logic [24:0] D;
  logic [29:0] AMULT;

  logic        ia_r, ib_r, ia_c, ib_c;
  logic [24:0] ad_r, ad_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Default configuration: all registers present.
  dsp_preadder_dreg dut (
    .clk      (clk),
    .RST_n    (RST_n),
    .CED      (CED),
    .CEAD     (CEAD),
    .CEINMODE (CEINMODE),
    .INMODE   (INMODE),
    .D        (D),
    .AMULT    (AMULT),
    .INMODE_A (ia_r),
    .INMODE_B (ib_r),
    .AD       (ad_r)
  );

  // Fully combinational configuration.
  dsp_preadder_dreg #(
    .DREG      (0),
    .ADREG     (0),
    .INMODEREG (0)
  ) dut_c (
    .clk      (clk),
    .RST_n    (RST_n),
    .CED      (CED),
    .CEAD     (CEAD),
    .CEINMODE (CEINMODE),
    .INMODE   (INMODE),
    .D        (D),
    .AMULT    (AMULT),
    .INMODE_A (ia_c),
    .INMODE_B (ib_c),
    .AD       (ad_c)
  );

  typedef struct {
    logic [4:0]  inmode;
    logic [24:0] d;
    logic [29:0] amult;
    logic [24:0] exp_ad;
    logic        exp_a;
    logic        exp_b;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [4:0] im, input logic [24:0] dd, input logic [29:0] am);
    INMODE = im;
    D      = dd;
    AMULT  = am;
  endtask

  initial begin
    vecs[0] = '{5'b00100, 25'd100,       30'd25,          25'd125,       1'b0, 1'b0};
    vecs[1] = '{5'b01100, 25'd10,        30'd30,          25'h1FFFFEC,   1'b0, 1'b0};
    vecs[2] = '{5'b00100, 25'h0FFFFFF,   30'd1,           25'h1000000,   1'b0, 1'b0};
    vecs[3] = '{5'b00010, 25'd5,         30'd77,          25'd0,         1'b0, 1'b0};
    vecs[4] = '{5'b00000, 25'd5,         30'd77,          25'd77,        1'b0, 1'b0};
    vecs[5] = '{5'b01000, 25'd5,         30'd77,          25'h1FFFFB3,   1'b0, 1'b0};
    vecs[6] = '{5'b00110, 25'd50,        30'd77,          25'd50,        1'b0, 1'b0};
    vecs[7] = '{5'b01110, 25'd50,        30'd77,          25'd50,        1'b0, 1'b0};
    vecs[8] = '{5'b10001, 25'd0,         30'd3,           25'd3,         1'b1, 1'b1};
    vecs[9] = '{5'b00100, 25'h1FFFFFF,   30'h3E000001,    25'd0,         1'b0, 1'b0};

    // Reset state
    RST_n = 1'b0; CED = 1'b1; CEAD = 1'b1; CEINMODE = 1'b1;
    apply(5'b10001, 25'd100, 30'd25);
    #1;
    chk("rst_ad", {7'd0, ad_r}, 32'd0);
    chk("rst_inmode_a", {31'd0, ia_r}, 32'd0);
    chk("rst_inmode_b", {31'd0, ib_r}, 32'd0);
    chk("rst_comb_ad", {7'd0, ad_c}, 32'd25);
    chk("rst_comb_inmode_a", {31'd0, ia_c}, 32'd1);
    step();
    step();
    chk("rst_held_ad", {7'd0, ad_r}, 32'd0);
    RST_n = 1'b1;

    // Table: comb DUT same cycle, registered DUT after two edges.
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].inmode, vecs[i].d, vecs[i].amult);
      #1;
      chk($sformatf("vec%0d_comb_ad", i), {7'd0, ad_c}, {7'd0, vecs[i].exp_ad});
      chk($sformatf("vec%0d_comb_a", i), {31'd0, ia_c}, {31'd0, vecs[i].exp_a});
      chk($sformatf("vec%0d_comb_b", i), {31'd0, ib_c}, {31'd0, vecs[i].exp_b});
      step();
      step();
      chk($sformatf("vec%0d_ad", i), {7'd0, ad_r}, {7'd0, vecs[i].exp_ad});
      chk($sformatf("vec%0d_inmode_a", i), {31'd0, ia_r}, {31'd0, vecs[i].exp_a});
      chk($sformatf("vec%0d_inmode_b", i), {31'd0, ib_r}, {31'd0, vecs[i].exp_b});
    end

    // INMODE reaches AD one cycle later than AMULT.
    apply(5'b00010, 25'd0, 30'd77);
    step(); step();
    chk("azero_ad", {7'd0, ad_r}, 32'd0);
    INMODE = 5'b00000;
    step();
    chk("inmode_lat1_ad", {7'd0, ad_r}, 32'd0);
    step();
    chk("inmode_lat2_ad", {7'd0, ad_r}, 32'd77);
    AMULT = 30'd12;
    step();
    chk("amult_lat1_ad", {7'd0, ad_r}, 32'd12);

    // D latency is two cycles.
    apply(5'b00100, 25'd100, 30'd25);
    step(); step();
    chk("d_base_ad", {7'd0, ad_r}, 32'd125);
    D = 25'd200;
    step();
    chk("d_lat1_ad", {7'd0, ad_r}, 32'd125);
    step();
    chk("d_lat2_ad", {7'd0, ad_r}, 32'd225);

    // CE low: AD and D_R hold across input changes.
    D = 25'd100;
    step(); step();
    chk("ce_base_ad", {7'd0, ad_r}, 32'd125);
    CED = 1'b0; CEAD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      D     = 25'd1000 + 25'(i);
      AMULT = 30'd500 + 30'(i);
      step();
      chk($sformatf("ce_hold%0d_ad", i), {7'd0, ad_r}, 32'd125);
    end
    apply(5'b00100, 25'd999, 30'd7);
    CEAD = 1'b1;
    step();
    chk("ce_resume_ad", {7'd0, ad_r}, 32'd107);
    CED = 1'b1;

    // Reset mid-cycle clears AD immediately; combinational path unaffected.
    apply(5'b00100, 25'd100, 30'd25);
    step(); step();
    chk("mid_base_ad", {7'd0, ad_r}, 32'd125);
    #2;
    RST_n = 1'b0;
    #1;
    chk("mid_rst_ad", {7'd0, ad_r}, 32'd0);
    chk("mid_rst_comb_ad", {7'd0, ad_c}, 32'd125);
    step();
    chk("mid_rst_held_ad", {7'd0, ad_r}, 32'd0);
    RST_n = 1'b1;
    step();
    // First edge after release loads AD from cleared INMODE_R: D term off.
    chk("post_rst1_ad", {7'd0, ad_r}, 32'd25);
    step();
    chk("post_rst2_ad", {7'd0, ad_r}, 32'd125);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
